// File: rtl/ir_cache_if.sv
// ir_cache_if: loader stream, reload control and decoder read port of the
// instruction cache. The optional parity-error flag exists only when
// IR_CACHE_PARITY_EN is defined.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef IR_ADDR_WIDTH
`define IR_ADDR_WIDTH 4
`endif

interface ir_cache_if #(
    parameter int DATA_WIDTH    = `DATA_WIDTH,
    parameter int IR_ADDR_WIDTH = `IR_ADDR_WIDTH
);
    logic                     i_load_valid;
    logic [DATA_WIDTH-1:0]    i_load_data;
    logic                     i_load_last;
    logic                     o_load_ready;
    logic                     i_reload;
    logic                     o_cash_init_done;
    logic [IR_ADDR_WIDTH:0]   o_fill_len;
    logic [IR_ADDR_WIDTH-1:0] i_irp;
    logic [DATA_WIDTH-1:0]    o_data;
`ifdef IR_CACHE_PARITY_EN
    logic                     o_parity_err;

    modport slave (
        input  i_load_valid, i_load_data, i_load_last, i_reload, i_irp,
        output o_load_ready, o_cash_init_done, o_fill_len, o_data, o_parity_err
    );
    modport master (
        output i_load_valid, i_load_data, i_load_last, i_reload, i_irp,
        input  o_load_ready, o_cash_init_done, o_fill_len, o_data, o_parity_err
    );
`else
    modport slave (
        input  i_load_valid, i_load_data, i_load_last, i_reload, i_irp,
        output o_load_ready, o_cash_init_done, o_fill_len, o_data
    );
    modport master (
        output i_load_valid, i_load_data, i_load_last, i_reload, i_irp,
        input  o_load_ready, o_cash_init_done, o_fill_len, o_data
    );
`endif
endinterface

// File: rtl/ir_cache.sv
// ir_cache: instruction store filled once from a valid/ready loader stream,
// then serving registered single-cycle reads to the decoder until reset or
// reload. Optional feature macro: IR_CACHE_PARITY_EN adds an even-parity bit
// per stored word and a sticky o_parity_err flag.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef IR_ADDR_WIDTH
`define IR_ADDR_WIDTH 4
`endif

module ir_cache #(
    parameter int DATA_WIDTH    = `DATA_WIDTH,
    parameter int IR_ADDR_WIDTH = `IR_ADDR_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    ir_cache_if.slave    bus
);
    localparam int DEPTH = 1 << IR_ADDR_WIDTH;
`ifdef IR_CACHE_PARITY_EN
    localparam int MEM_WIDTH = DATA_WIDTH + 1;
`else
    localparam int MEM_WIDTH = DATA_WIDTH;
`endif
    localparam logic [IR_ADDR_WIDTH-1:0] LAST_PTR = '1;

    typedef enum logic {
        FILL  = 1'b0,
        READY = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [IR_ADDR_WIDTH:0] len_q, len_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic                   perr_q, perr_d;
    logic [MEM_WIDTH-1:0]   mem [DEPTH];

    logic                     loadReady;
    logic                     xfer;
    logic                     finalXfer;
    logic                     readHit;
    logic [IR_ADDR_WIDTH-1:0] wrPtr;
    logic [MEM_WIDTH-1:0]     rdWord;
    logic [MEM_WIDTH-1:0]     wrWord;

    // The write pointer never wraps: FILL is left at DEPTH-1, so the low
    // bits of the fill length are the next address to write.
    assign wrPtr = len_q[IR_ADDR_WIDTH-1:0];

`ifdef IR_CACHE_PARITY_EN
    assign wrWord = {^bus.i_load_data, bus.i_load_data};
`else
    assign wrWord = bus.i_load_data;
`endif

    // Next-state, handshake and read-data selection; reload overrides everything.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        data_d    = '0;
        perr_d    = perr_q;
        loadReady = (state_q == FILL) && !rst;
        xfer      = bus.i_load_valid && loadReady;
        finalXfer = xfer && (bus.i_load_last || (wrPtr == LAST_PTR));
        readHit   = (state_q == READY) && ({1'b0, bus.i_irp} < len_q);
        rdWord    = mem[bus.i_irp];

        if (readHit) begin
`ifdef IR_CACHE_PARITY_EN
            if (^rdWord) begin
                perr_d = 1'b1;
            end else begin
                data_d = rdWord[DATA_WIDTH-1:0];
            end
`else
            data_d = rdWord[DATA_WIDTH-1:0];
`endif
        end

        case (state_q)
            FILL: begin
                if (bus.i_reload) begin
                    len_d = '0;
                end else if (xfer) begin
                    len_d = len_q + (IR_ADDR_WIDTH+1)'(1);
                    if (finalXfer) begin
                        state_d = READY;
                    end
                end
            end
            READY: begin
                if (bus.i_reload) begin
                    state_d = FILL;
                    len_d   = '0;
                end
            end
            default: begin
                state_d = FILL;
                len_d   = '0;
            end
        endcase

        if (bus.i_reload) begin
            data_d = '0;
            perr_d = 1'b0;
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            len_q   <= '0;
            data_q  <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            data_q  <= data_d;
            perr_q  <= perr_d;
        end
    end

    // Program storage; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (xfer) begin
            mem[wrPtr] <= wrWord;
        end
    end

    assign bus.o_load_ready     = loadReady;
    assign bus.o_cash_init_done = (state_q == READY);
    assign bus.o_fill_len       = len_q;
    assign bus.o_data           = data_q;
`ifdef IR_CACHE_PARITY_EN
    assign bus.o_parity_err     = perr_q;
`endif

endmodule

// File: tb/tb_ir_cache.sv
// tb_ir_cache: directed scenarios plus randomized traffic, checked every
// cycle against a behavioural model of the cache kept in the bench.
module tb_ir_cache;
    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    ir_cache_if #(.DATA_WIDTH(DW), .IR_ADDR_WIDTH(AW)) bus();

    ir_cache #(.DATA_WIDTH(DW), .IR_ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int fails  = 0;

    bit            mValid  = 1'b0;
    bit            mLoaded = 1'b0;
    int            mLen    = 0;
    logic [DW-1:0] mMem [DEPTH];
    bit            mBad [DEPTH];
    logic [DW-1:0] mData = '0;
    bit            mPerr = 1'b0;

    // Compare one DUT value against its expected value and log failures.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of loader/decoder inputs just after a rising edge.
    task automatic applyStimulus(input bit v, input logic [DW-1:0] d, input bit l,
                                 input bit rl, input int irp);
        @(posedge clk);
        #1;
        bus.i_load_valid = v;
        bus.i_load_data  = d;
        bus.i_load_last  = l;
        bus.i_reload     = rl;
        bus.i_irp        = AW'(irp);
    endtask

    task automatic idle(input int n, input int irp);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, irp);
    endtask

    // Behavioural model: loaded program as an array plus a length, updated per edge.
    always @(posedge clk) begin
        logic [DW-1:0] rv;
        bit            rerr;
        bit            acc;
        bit            isFinal;
        if (rst) begin
            mValid  = 1'b1;
            mLoaded = 1'b0;
            mLen    = 0;
            mData   = '0;
            mPerr   = 1'b0;
        end else if (mValid) begin
            rv   = '0;
            rerr = 1'b0;
            if (mLoaded && int'(bus.i_irp) < mLen) begin
                if (mBad[bus.i_irp]) rerr = 1'b1;
                else rv = mMem[bus.i_irp];
            end
            acc = !mLoaded && bus.i_load_valid;
            isFinal = bus.i_load_last || (mLen == DEPTH - 1);
            if (acc) begin
                mMem[mLen] = bus.i_load_data;
                mBad[mLen] = 1'b0;
            end
            if (bus.i_reload) begin
                mLoaded = 1'b0;
                mLen    = 0;
                mData   = '0;
                mPerr   = 1'b0;
            end else begin
                mData = rv;
                if (rerr) mPerr = 1'b1;
                if (acc) begin
                    mLen++;
                    if (isFinal) mLoaded = 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (mValid) begin
            checkOutput("load_ready", 64'(bus.o_load_ready), 64'(!rst && !mLoaded));
            checkOutput("init_done",  64'(bus.o_cash_init_done), 64'(mLoaded));
            checkOutput("fill_len",   64'(bus.o_fill_len), 64'(mLen));
            checkOutput("data",       64'(bus.o_data), 64'(mData));
`ifdef IR_CACHE_PARITY_EN
            checkOutput("parity_err", 64'(bus.o_parity_err), 64'(mPerr));
`endif
        end
    end

    logic [DW-1:0] a [4];

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mMem[i] = '0;
            mBad[i] = 1'b0;
        end
        bus.i_load_valid = 1'b0;
        bus.i_load_data  = '0;
        bus.i_load_last  = 1'b0;
        bus.i_reload     = 1'b0;
        bus.i_irp        = '0;

        // Reset for two edges, ready must be low during reset.
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checkOutput("lit_ready_in_reset", 64'(bus.o_load_ready), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("lit_ready_after_reset", 64'(bus.o_load_ready), 64'd1);
        checkOutput("lit_len_after_reset", 64'(bus.o_fill_len), 64'd0);

        // Four-word program, then read address 2.
        for (int i = 0; i < 4; i++) a[i] = $urandom;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, a[i], i == 3, 1'b0, 0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 2);
        @(negedge clk);
        checkOutput("lit_done_after_A3", 64'(bus.o_cash_init_done), 64'd1);
        checkOutput("lit_len4", 64'(bus.o_fill_len), 64'd4);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 2);
        @(negedge clk);
        checkOutput("lit_read_A2", 64'(bus.o_data), 64'(a[2]));

        // Toggled valid with last on the second transfer.
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 0);
        applyStimulus(1'b1, 32'h1111_0000, 1'b0, 1'b0, 0);
        applyStimulus(1'b0, 32'hDEAD_0000, 1'b1, 1'b0, 0);
        applyStimulus(1'b1, 32'h2222_0001, 1'b1, 1'b0, 0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1);
        @(negedge clk);
        checkOutput("lit_len2", 64'(bus.o_fill_len), 64'd2);
        checkOutput("lit_done_toggle", 64'(bus.o_cash_init_done), 64'd1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1);
        @(negedge clk);
        checkOutput("lit_read_toggle", 64'(bus.o_data), 64'h2222_0001);

        // Full fill with no last marker, plus an extra word that must be refused.
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 0);
        for (int i = 0; i <= DEPTH; i++) applyStimulus(1'b1, 32'hF000_0000 + i, 1'b0, 1'b0, 0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 0);
        @(negedge clk);
        checkOutput("lit_len_full", 64'(bus.o_fill_len), 64'(DEPTH));
        checkOutput("lit_ready_full", 64'(bus.o_load_ready), 64'd0);
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, i);
        idle(1, 0);

        // Three-word program, back-to-back reads including out-of-program addresses.
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'hC000_0000 + i, i == 2, 1'b0, 0);
        foreach (a[i]) applyStimulus(1'b0, '0, 1'b0, 1'b0, i);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 5);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 0);
        @(negedge clk);
        checkOutput("lit_read_oob5", 64'(bus.o_data), 64'd0);

        // Reload then a single-word program.
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 0);
        applyStimulus(1'b1, 32'hB0B0_B0B0, 1'b1, 1'b0, 0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1);
        @(negedge clk);
        checkOutput("lit_read_B0", 64'(bus.o_data), 64'hB0B0_B0B0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 0);
        @(negedge clk);
        checkOutput("lit_read_oob1", 64'(bus.o_data), 64'd0);

        // Reload coinciding with a final transfer: reload wins.
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 0);
        applyStimulus(1'b1, 32'h5555_5555, 1'b1, 1'b1, 0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 0);
        @(negedge clk);
        checkOutput("lit_reload_wins_len", 64'(bus.o_fill_len), 64'd0);

        // Reset in the middle of a fill, then a one-word program.
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 32'hAB00_0000 + i, 1'b0, 1'b0, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        bus.i_load_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("lit_len_after_midrst", 64'(bus.o_fill_len), 64'd0);
        checkOutput("lit_done_after_midrst", 64'(bus.o_cash_init_done), 64'd0);
        applyStimulus(1'b1, 32'h0123_4567, 1'b1, 1'b0, 0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 0);
        @(negedge clk);
        checkOutput("lit_len1", 64'(bus.o_fill_len), 64'd1);

`ifdef IR_CACHE_PARITY_EN
        // Corrupt a stored bit and read it back; the error is sticky until reload.
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h7700_0000 + i, i == 2, 1'b0, 0);
        idle(1, 0);
        dut.mem[1][0] = ~dut.mem[1][0];
        mBad[1] = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 0);
        @(negedge clk);
        checkOutput("lit_parity_err", 64'(bus.o_parity_err), 64'd1);
        checkOutput("lit_parity_data", 64'(bus.o_data), 64'd0);
        idle(3, 2);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 0);
        idle(1, 0);
`endif

        // Randomized traffic, including rare resets and reloads.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(199) == 0) begin
                @(posedge clk);
                #1 rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
            end
            applyStimulus($urandom_range(1) == 1, $urandom, $urandom_range(7) == 0,
                          $urandom_range(39) == 0, $urandom_range(DEPTH - 1));
        end
        idle(2, 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
